adc8_conv_sched: RTL and testbench
==================================

ADC8_CONV_SCHED -- requirements
Module: adc8_conv_sched

Interface
- REQ-001: Parameter SETTLE_CYCLES, default 4: cycles the mux is held on a channel before sampling; legal range 1..255.
- REQ-002: Parameter AVG_LOG2, default 2: log2 of samples averaged per conversion; legal range 0..4.
- REQ-003: Clock and reset: one clock; reset is synchronous and active-high.
- REQ-004: clk  input  1  single clock, all state updates on its rising edge.
- REQ-005: rst  input  1  synchronous active-high reset.
- REQ-006: req  input  4  per-channel conversion request, level-sensitive.
- REQ-007: ack  output  4  one-hot, one-cycle pulse on result handshake for the served channel.
- REQ-008: mux_sel  output  2  analog input mux select driving the flash ADC vin source.
- REQ-009: sample_en  output  1  high during each cycle whose adc_code is captured.
- REQ-010: adc_code  input  8  flash ADC straight-binary output code.
- REQ-011: busy  output  1  high whenever the state is not IDLE.
- REQ-012: res_valid  output  1  result available.
- REQ-013: res_ready  input  1  consumer accepts the result.
- REQ-014: res_data  output  8  averaged code.
- REQ-015: res_ch  output  2  channel of res_data.
- REQ-016: res_ovr  output  1  overrange flag; see Configuration.

Function
- REQ-017: FSM states IDLE, SETTLE, SAMPLE and DONE SHALL be implemented.
- REQ-018: IDLE: on an edge with any req bit high, grant by round-robin starting at (last served + 1) mod 4, load mux_sel with the granted channel, and go to SETTLE.
- REQ-019: SETTLE: stay exactly SETTLE_CYCLES cycles, then go to SAMPLE; mux_sel is stable throughout.
- REQ-020: SAMPLE: sample_en=1 for 2^AVG_LOG2 consecutive cycles, and each edge adds adc_code into the accumulator.
- REQ-021: Accumulator width SHALL be 8+AVG_LOG2 bits, unsigned, so overflow cannot occur.
- REQ-022: On the last sample edge, res_data = accumulated sum >> AVG_LOG2 (truncating), res_ch = granted channel, then go to DONE.
- REQ-023: Latency: req sampled at edge k in IDLE gives res_valid high after edge k+SETTLE_CYCLES+2^AVG_LOG2 (defaults: k+8).
- REQ-024: DONE: res_valid=1; res_data, res_ch and res_ovr are held stable until res_valid and res_ready are both high at an edge.
- REQ-025: On the DONE handshake edge: ack[res_ch] pulses high for the next cycle, the last-served pointer updates, and the FSM returns to IDLE.
- REQ-026: No conversion starts while in DONE, and req changes during a conversion do not affect the ongoing conversion.
- REQ-027: A req still high after its ack is re-eligible, but only in its round-robin turn.
- REQ-028: Only the IDLE arbitration edge samples req; a req that drops before that edge is ignored.

Reset
- REQ-029: During rst, state = IDLE, mux_sel = 0, sample_en = 0, busy = 0, res_valid = 0, res_data = 0, res_ch = 0, res_ovr = 0, ack = 0, and the accumulator and counters are cleared.
- REQ-030: After reset, the last-served pointer = 3, so channel 0 has first priority.
- REQ-031: Reset asserted in any state, including mid-SAMPLE or DONE, takes effect at the next edge and drops any pending result with no ack.

Configuration
- REQ-032: Macro OVERRANGE_FLAG_EN defined: res_ovr = 1 if any sample in the conversion equals 8'hFF; the flag clears at the start of each conversion.
- REQ-033: Macro OVERRANGE_FLAG_EN undefined: the res_ovr port is still present but tied to 0, with no detection logic.

Verification
- REQ-034: Defaults, req=4'b0100 at edge k, adc_code=100 constant -> mux_sel=2 after edge k, sample_en high for 4 cycles, res_valid after edge k+8 with res_data=100 and res_ch=2, res_ready=1 gives ack=4'b0100 for one cycle.
- REQ-035: adc_code 10,11,12,13 on the four sample edges -> res_data=11 (sum 46 >> 2).
- REQ-036: req=4'b1111 held high with res_ready=1 -> service order 0,1,2,3,0, each with res_ch matching.
- REQ-037: res_ready=0 for 5 cycles in DONE -> res_data and res_ch stable, ack=0, busy=1, no sample_en; ack fires only on the handshake edge.
- REQ-038: rst pulsed during the second SAMPLE cycle -> next cycle all outputs at reset values, no ack; the next req=4'b0001 completes normally.
- REQ-039: One sample equal to 255 among 0x80 samples -> res_ovr=1 with OVERRANGE_FLAG_EN and 0 without; res_data=(3*128+255)>>2=159 in both builds.

Source files
------------

// File: rtl/adc8_conv_if.sv
// Handshake/bus bundle between adc8_conv_sched and its environment.
// master: the scheduler side; slave: requesters, flash ADC and result consumer.
interface adc8_conv_if;
    logic [3:0] req;
    logic [3:0] ack;
    logic [1:0] mux_sel;
    logic       sample_en;
    logic [7:0] adc_code;
    logic       busy;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [1:0] res_ch;
    logic       res_ovr;

    modport master (
        input  req, adc_code, res_ready,
        output ack, mux_sel, sample_en, busy, res_valid, res_data, res_ch, res_ovr
    );

    modport slave (
        output req, adc_code, res_ready,
        input  ack, mux_sel, sample_en, busy, res_valid, res_data, res_ch, res_ovr
    );
endinterface

// File: rtl/adc8_conv_sched.sv
// Round-robin 4-channel conversion scheduler for a flash ADC: settle, average, hand off.
// Optional: define OVERRANGE_FLAG_EN to flag conversions that saw a full-scale (8'hFF) sample.
module adc8_conv_sched #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned AVG_LOG2      = 2
) (
    input logic         clk,
    input logic         rst,
    adc8_conv_if.master bus
);
    localparam int unsigned AW = 8 + AVG_LOG2;
    localparam int unsigned CW = 8;
    localparam int unsigned NS = 1 << AVG_LOG2;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      last, last_nxt;
    logic [1:0]      mux_sel, mux_sel_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [AW-1:0]   acc, acc_nxt, sum_c;
    logic [7:0]      res_data, res_data_nxt;
    logic [1:0]      res_ch, res_ch_nxt;
    logic [3:0]      ack, ack_nxt;
    logic            sample_en, busy, res_valid;
    logic            found_c;
    logic [1:0]      gnt_c;
`ifdef OVERRANGE_FLAG_EN
    logic            ovr, ovr_nxt, res_ovr, res_ovr_nxt;
`endif

    // Round-robin search starting one past the last served channel.
    always_comb begin
        found_c = 1'b0;
        gnt_c   = last;
        for (int i = 1; i <= 4; i++) begin
            if (!found_c && bus.req[2'(last + 2'(i))]) begin
                found_c = 1'b1;
                gnt_c   = 2'(last + 2'(i));
            end
        end
    end

    assign sum_c = acc + AW'(bus.adc_code);

    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        mux_sel_nxt  = mux_sel;
        cnt_nxt      = cnt;
        acc_nxt      = acc;
        res_data_nxt = res_data;
        res_ch_nxt   = res_ch;
        ack_nxt      = 4'b0000;
`ifdef OVERRANGE_FLAG_EN
        ovr_nxt      = ovr;
        res_ovr_nxt  = res_ovr;
`endif
        case (state)
            IDLE: begin
                if (found_c) begin
                    state_nxt   = SETTLE;
                    mux_sel_nxt = gnt_c;
                    cnt_nxt     = '0;
                    acc_nxt     = '0;
`ifdef OVERRANGE_FLAG_EN
                    ovr_nxt     = 1'b0;
`endif
                end
            end
            SETTLE: begin
                if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    state_nxt = SAMPLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            SAMPLE: begin
                acc_nxt = sum_c;
`ifdef OVERRANGE_FLAG_EN
                ovr_nxt = ovr | (bus.adc_code == 8'hFF);
`endif
                if (cnt == CW'(NS - 1)) begin
                    state_nxt    = DONE;
                    res_data_nxt = 8'(sum_c >> AVG_LOG2);
                    res_ch_nxt   = mux_sel;
`ifdef OVERRANGE_FLAG_EN
                    res_ovr_nxt  = ovr_nxt;
`endif
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                    ack_nxt   = 4'(1) << res_ch;
                    last_nxt  = res_ch;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 2'd3;
            mux_sel   <= '0;
            cnt       <= '0;
            acc       <= '0;
            res_data  <= '0;
            res_ch    <= '0;
            ack       <= '0;
            sample_en <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
`ifdef OVERRANGE_FLAG_EN
            ovr       <= 1'b0;
            res_ovr   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            mux_sel   <= mux_sel_nxt;
            cnt       <= cnt_nxt;
            acc       <= acc_nxt;
            res_data  <= res_data_nxt;
            res_ch    <= res_ch_nxt;
            ack       <= ack_nxt;
            sample_en <= (state_nxt == SAMPLE);
            busy      <= (state_nxt != IDLE);
            res_valid <= (state_nxt == DONE);
`ifdef OVERRANGE_FLAG_EN
            ovr       <= ovr_nxt;
            res_ovr   <= res_ovr_nxt;
`endif
        end
    end

    assign bus.ack       = ack;
    assign bus.mux_sel   = mux_sel;
    assign bus.sample_en = sample_en;
    assign bus.busy      = busy;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_ch    = res_ch;
`ifdef OVERRANGE_FLAG_EN
    assign bus.res_ovr   = res_ovr;
`else
    assign bus.res_ovr   = 1'b0;
`endif
endmodule

// File: tb/tb_adc8_conv_sched.sv
// Scoreboard bench for adc8_conv_sched: driver predicts each conversion, monitor checks the handoff.
module tb_adc8_conv_sched;
    localparam int S = 4;
    localparam int A = 2;
    localparam int N = 1 << A;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adc8_conv_if bus ();

    adc8_conv_sched #(.SETTLE_CYCLES(S), .AVG_LOG2(A)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int ch;
        int data;
        int ovr;
        int tvalid;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         last_m = 3;
    logic [7:0] samp [N];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arbitration: first requesting channel after the last one served.
    function automatic int rr(input int last, input logic [3:0] r);
        for (int i = 1; i <= 4; i++)
            if (r[(last + i) % 4]) return (last + i) % 4;
        return -1;
    endfunction

    task automatic chk_rst(input string tag);
        chk({tag, "_busy"},      bus.busy,      0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_sample_en"}, bus.sample_en, 0);
        chk({tag, "_mux_sel"},   bus.mux_sel,   0);
        chk({tag, "_res_data"},  bus.res_data,  0);
        chk({tag, "_res_ch"},    bus.res_ch,    0);
        chk({tag, "_res_ovr"},   bus.res_ovr,   0);
        chk({tag, "_ack"},       bus.ack,       0);
    endtask

    task automatic rand_samples();
        foreach (samp[i]) samp[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
    endtask

    // Called at a falling edge while the DUT is idle; returns at the falling edge after the handshake.
    task automatic conv(input logic [3:0] r, input int hold, input bit keep);
        int k, ch, sum, ovr, se_cnt;
        ch = rr(last_m, r);
        sum = 0;
        ovr = 0;
        foreach (samp[i]) begin
            sum += int'(samp[i]);
            if (samp[i] == 8'hFF) ovr = 1;
        end
`ifndef OVERRANGE_FLAG_EN
        ovr = 0;
`endif
        k = cyc + 1;
        q.push_back('{ch, sum >> A, ovr, k + S + N});
        bus.req = r;
        bus.res_ready = 1'b0;
        se_cnt = 0;
        for (int t = 1; t <= S + N; t++) begin
            @(negedge clk);
            if (t == 1) begin
                chk("mux_sel", bus.mux_sel, ch);
                chk("busy_start", bus.busy, 1);
            end
            se_cnt += int'(bus.sample_en);
            if (!keep) bus.req = 4'($urandom);
            bus.adc_code = (t > S) ? samp[t - S - 1] : 8'($urandom);
        end
        repeat (hold + 1) begin
            @(negedge clk);
            se_cnt += int'(bus.sample_en);
            chk("busy_done", bus.busy, 1);
            bus.adc_code = 8'($urandom);
        end
        chk("sample_en_cycles", se_cnt, N);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        last_m = ch;
    endtask

    // Monitor: looks just after each falling edge, once the driver has settled its inputs.
    exp_t       cur;
    logic [3:0] exp_ack = '0;
    logic [3:0] exp_ack_n;
    logic       pv = 1'b0;
    logic [7:0] pd;
    logic [1:0] pc;
    logic       po;

    always @(negedge clk) begin
        #1;
        if (exp_ack != 4'b0000 || bus.ack != 4'b0000) chk("ack", bus.ack, exp_ack);
        exp_ack_n = 4'b0000;
        if (bus.res_valid && !pv) begin
            if (q.size() == 0) chk("unexpected_valid", 1, 0);
            else               chk("latency", cyc, q[0].tvalid);
        end
        if (bus.res_valid && pv)
            chk("res_hold", int'({bus.res_data, bus.res_ch, bus.res_ovr}), int'({pd, pc, po}));
        if (bus.res_valid && bus.res_ready && !rst) begin
            if (q.size() == 0) chk("result_without_expect", 1, 0);
            else begin
                cur = q.pop_front();
                chk("res_ch",   bus.res_ch,   cur.ch);
                chk("res_data", bus.res_data, cur.data);
                chk("res_ovr",  bus.res_ovr,  cur.ovr);
                exp_ack_n = 4'(1) << cur.ch;
            end
        end
        pv = bus.res_valid;
        pd = bus.res_data;
        pc = bus.res_ch;
        po = bus.res_ovr;
        exp_ack = exp_ack_n;
    end

    initial begin
        logic [3:0] r;
        rst = 1'b1;
        bus.req = '0;
        bus.adc_code = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_rst("reset");
        rst = 1'b0;
        last_m = 3;

        foreach (samp[i]) samp[i] = 8'd100;
        conv(4'b0100, 0, 1'b1);
        for (int i = 0; i < N; i++) samp[i] = 8'(10 + i);
        conv(4'b0010, 1, 1'b0);
        bus.req = '0;

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_m = 3;
        chk_rst("idle_reset");

        for (int i = 0; i < 5; i++) begin
            rand_samples();
            conv(4'b1111, (i == 2) ? 5 : 0, 1'b1);
        end
        bus.req = '0;

        samp[0] = 8'h80; samp[1] = 8'hFF; samp[2] = 8'h80; samp[3] = 8'h80;
        conv(4'b1000, 0, 1'b0);
        bus.req = '0;

        repeat (40) begin
            rand_samples();
            r = '0;
            while (r == 4'b0000) r = 4'($urandom);
            conv(r, $urandom_range(0, 5), 1'b0);
            bus.req = '0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        bus.req = 4'b0100;
        bus.adc_code = 8'd100;
        repeat (S + 2) @(negedge clk);
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        chk_rst("midsample_reset");
        last_m = 3;

        rand_samples();
        conv(4'b0001, 0, 1'b0);
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
